// File: rtl/recovery_sequencer_pkg.sv
// recovery_sequencer_pkg: shared widths, defaults and state encoding for the recovery sequencer
`ifndef XLEN
`define XLEN 32
`endif
`ifndef N_WAY
`define N_WAY 4
`endif
package recovery_sequencer_pkg;
  localparam int XLEN = `XLEN;
  localparam int N_WAY = `N_WAY;
  localparam int SR_W = $clog2(N_WAY) + 1;
  localparam int DEF_MAX_OUT_STORES = 16;
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FLUSH      = 3'd1,
    S_DRAIN      = 3'd2,
    S_REDIRECT   = 3'd3,
    S_HALT_DRAIN = 3'd4,
    S_HALTED     = 3'd5
  } recov_state_e;
endpackage

// File: rtl/recovery_sequencer_if.sv
// recovery_sequencer_if: retire-side inputs and recovery outputs between ROB, store queue and fetch
interface recovery_sequencer_if;
  import recovery_sequencer_pkg::*;
  logic            branch_haz;
  logic [XLEN-1:0] br_target_pc;
  logic            retire_halt;
  logic [SR_W-1:0] store_num_ret;
  logic            store_done;
  logic            fetch_ack;
  logic            flush;
  logic            stall_dispatch;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            cpu_halted;
  logic            store_err;
  logic [2:0]      state_dbg;
`ifdef RECOVERY_PERF_CNT_EN
  logic [31:0]     recovery_count;
  logic [31:0]     stall_cycles;
`endif
  modport master (
    output branch_haz, br_target_pc, retire_halt, store_num_ret, store_done, fetch_ack,
    input
`ifdef RECOVERY_PERF_CNT_EN
    recovery_count, stall_cycles,
`endif
    flush, stall_dispatch, redirect_valid, redirect_pc, cpu_halted, store_err, state_dbg
  );
  modport slave (
    input branch_haz, br_target_pc, retire_halt, store_num_ret, store_done, fetch_ack,
    output
`ifdef RECOVERY_PERF_CNT_EN
    recovery_count, stall_cycles,
`endif
    flush, stall_dispatch, redirect_valid, redirect_pc, cpu_halted, store_err, state_dbg
  );
endinterface

// File: rtl/recovery_sequencer_store_drain_counter.sv
// store_drain_counter: saturating count of retired-but-unwritten stores with sticky range error
module store_drain_counter
  import recovery_sequencer_pkg::*;
#(
  parameter int MAX = DEF_MAX_OUT_STORES,
  localparam int W = $clog2(MAX) + 1,
  localparam int AW = W + SR_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SR_W-1:0] inc_i,
  input  logic            dec_i,
  output logic [W-1:0]    cnt_next_o,
  output logic            err_o
);
  logic [W-1:0]  cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [AW-1:0] sum, diff;
  // An underflow wraps diff to all-ones, so one range test flags both error kinds
  always_comb begin
    sum = AW'(cnt_q) + AW'(inc_i);
    diff = sum - AW'(dec_i);
    cnt_d = (diff > AW'(MAX)) ? ((sum == '0) ? '0 : W'(MAX)) : diff[W-1:0];
    err_d = err_q | (diff > AW'(MAX));
  end
  // Counter and sticky error registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign cnt_next_o = cnt_d;
  assign err_o = err_q;
endmodule

// File: rtl/recovery_sequencer.sv
// recovery_sequencer: flush/drain/redirect and halt sequencing after retire-time events (optional perf counters: RECOVERY_PERF_CNT_EN)
module recovery_sequencer
  import recovery_sequencer_pkg::*;
#(
  parameter int MAX_OUT_STORES = DEF_MAX_OUT_STORES
) (
  input logic clock,
  input logic reset,
  recovery_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUT_STORES) + 1;
  recov_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_next;
  logic            err;
  store_drain_counter #(.MAX(MAX_OUT_STORES)) u_cnt (
    .clock     (clock),
    .reset     (reset),
    .inc_i     (bus.store_num_ret),
    .dec_i     (bus.store_done),
    .cnt_next_o(cnt_next),
    .err_o     (err)
  );
  // State and redirect target registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  // Next state: halt beats a same-cycle branch because it is the older instruction
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    case (state_q)
      S_IDLE: begin
        state_d = bus.retire_halt ? S_HALT_DRAIN : bus.branch_haz ? S_FLUSH : S_IDLE;
        pc_d = (bus.branch_haz && !bus.retire_halt) ? bus.br_target_pc : pc_q;
      end
      S_FLUSH:      state_d = S_DRAIN;
      S_DRAIN:      state_d = (cnt_next == '0) ? S_REDIRECT : S_DRAIN;
      S_REDIRECT:   state_d = bus.fetch_ack ? S_IDLE : S_REDIRECT;
      S_HALT_DRAIN: state_d = (cnt_next == '0) ? S_HALTED : S_HALT_DRAIN;
      S_HALTED:     state_d = S_HALTED;
      default:      state_d = S_IDLE;
    endcase
  end
  // Outputs decoded from state and registers only
  always_comb begin
    bus.flush = state_q == S_FLUSH;
    bus.stall_dispatch = state_q != S_IDLE;
    bus.redirect_valid = state_q == S_REDIRECT;
    bus.cpu_halted = state_q == S_HALTED;
    bus.redirect_pc = pc_q;
    bus.store_err = err;
    bus.state_dbg = state_q;
  end
`ifdef RECOVERY_PERF_CNT_EN
  logic [31:0] rc_q, rc_d, sc_q, sc_d;
  assign rc_d = (state_q == S_IDLE && state_d == S_FLUSH && ~&rc_q) ? rc_q + 32'd1 : rc_q;
  assign sc_d = (state_q != S_IDLE && ~&sc_q) ? sc_q + 32'd1 : sc_q;
  // Saturating recovery and stall-cycle counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rc_q <= '0;
      sc_q <= '0;
    end else begin
      rc_q <= rc_d;
      sc_q <= sc_d;
    end
  end
  assign bus.recovery_count = rc_q;
  assign bus.stall_cycles = sc_q;
`endif
endmodule

// File: doc/recovery_sequencer.md
Name: recovery_sequencer

Overview:
- Sequences pipeline recovery around the ROB/map-table/free-list cluster.
- On a retire-time branch mispredict (branch_haz) it flushes the front end and stalls dispatch until all retired stores have drained to memory, then redirects fetch with a handshake.
- On a retired halt or illegal instruction it drains stores and raises a sticky halted flag.
- Sits between the ROB top, the store queue and fetch.

Parameters:
- MAX_OUT_STORES, 16, maximum retired-but-unwritten stores tracked; counter width CNT_W = $clog2(MAX_OUT_STORES)+1.
- N_WAY, `N_WAY, retire width; store_num_ret width is $clog2(N_WAY)+1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- branch_haz  in  1  mispredicted branch retired this cycle.
- br_target_pc  in  `XLEN  correct target; sampled with branch_haz.
- retire_halt  in  1  halt or illegal instruction retired this cycle.
- store_num_ret  in  $clog2(N_WAY)+1  stores retired this cycle.
- store_done  in  1  store queue wrote one store to memory this cycle.
- fetch_ack  in  1  fetch accepted the redirect.
- flush  out  1  one-cycle flush pulse to fetch, dispatch and RS.
- stall_dispatch  out  1  blocks dispatch.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  `XLEN  redirect target.
- cpu_halted  out  1  sticky halt-complete flag.
- store_err  out  1  sticky counter underflow/overflow error.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset (reset=0, async): state=IDLE, outstanding count=0, all outputs 0, redirect_pc=0.
- Outstanding counter, updated every cycle in every state: cnt_next = cnt + store_num_ret - store_done.
  - store_done while cnt+store_num_ret==0: no decrement; store_err<=1.
  - Result > MAX_OUT_STORES: saturate at MAX_OUT_STORES; store_err<=1.
- States (3-bit): IDLE=0, FLUSH=1, DRAIN=2, REDIRECT=3, HALT_DRAIN=4, HALTED=5.
- IDLE:
  - retire_halt -> HALT_DRAIN.
  - Otherwise branch_haz -> FLUSH, and latch redirect_pc<=br_target_pc.
  - branch_haz and retire_halt in the same cycle: halt wins, no flush, no redirect (halt is necessarily the older instruction).
- FLUSH: flush=1 and stall_dispatch=1 for exactly this one cycle -> DRAIN. Inputs branch_haz and retire_halt are ignored here.
- DRAIN: stall_dispatch=1.
  - When cnt_next==0 -> REDIRECT.
  - If cnt is already 0 on entry, DRAIN still lasts one cycle.
- REDIRECT: redirect_valid=1, stall_dispatch=1, redirect_pc held stable.
  - On fetch_ack -> IDLE; redirect_valid drops the next cycle.
  - Minimum branch_haz-to-redirect latency: 3 cycles (IDLE->FLUSH->DRAIN->REDIRECT).
- HALT_DRAIN: stall_dispatch=1. When cnt_next==0 -> HALTED.
- HALTED: stall_dispatch=1, cpu_halted=1. Leaves only on reset.
- branch_haz arriving in FLUSH/DRAIN/REDIRECT/HALT*: ignored. The ROB cannot retire a younger branch while it is flushed and stalled.
- Reset asserted mid-sequence: immediate return to IDLE, any pending redirect dropped, counter cleared.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: RECOVERY_PERF_CNT_EN.
- Defined:
  - Adds 32-bit output ports recovery_count (increments on each IDLE->FLUSH) and stall_cycles (increments each cycle stall_dispatch=1).
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package (sys_defs) gets:
  - RECOV_STATE enum typedef (6 states, 3 bits).
  - MAX_OUT_STORES default constant.
- `XLEN and `N_WAY come from existing defines.
- One sub-module: store_drain_counter (saturating up/down counter with underflow/overflow error). The FSM is kept in the top module.

Test Plan:
- Reset, then branch_haz=1 with br_target_pc=0x100 and cnt=0 -> flush high in cycle 1; redirect_valid=1 with pc=0x100 in cycle 3; fetch_ack in cycle 5 -> IDLE in cycle 6; stall_dispatch high in cycles 1-5.
- store_num_ret=2 for two cycles (cnt=4), then branch_haz -> DRAIN holds until four store_done pulses; REDIRECT the cycle after cnt_next==0.
- branch_haz and retire_halt same cycle with cnt=1 -> no flush pulse; HALT_DRAIN until store_done; cpu_halted=1 next cycle and stays set for 20 cycles.
- store_done with cnt=0 -> cnt stays 0, store_err=1 and sticky; store_num_ret pushing cnt past 16 -> cnt=16, store_err=1.
- reset asserted asynchronously mid-REDIRECT -> redirect_valid=0 immediately without a clock edge; state_dbg=0.
- With RECOVERY_PERF_CNT_EN: two full recoveries of 5 stall cycles each -> recovery_count=2, stall_cycles=10.
